// File: rtl/cpu_pkg.sv
// Shared processor definitions: datapath widths and register index type.
// Used by the register file and by the instruction decoder.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_32.sv
// One general-purpose register.
// Loads d on a rising clk when en is high; cleared asynchronously by rst_n.
module register_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file.
// Register 0 reads as zero; optional same-cycle write-through on reads.
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [NREGS];

    assign regs[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        logic we;

        assign we = RegWrite && (WriteReg == ADDR_W'(i));

        register_32 #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (we),
            .d     (WriteData),
            .q     (regs[i])
        );
    end

    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    logic             hit1;
    logic             hit2;

    assign stored1 = regs[ReadReg1];
    assign stored2 = regs[ReadReg2];

    // Bypass compare runs beside the storage mux; rst_n gate keeps reads at 0 in reset
    assign hit1 = BYPASS && rst_n && RegWrite && (WriteReg == ReadReg1);
    assign hit2 = BYPASS && rst_n && RegWrite && (WriteReg == ReadReg2);

    always_comb begin
        ReadData1 = stored1;
        if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end else if (hit1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = stored2;
        if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end else if (hit2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file, run with write-through on and off
// side by side on the same stimulus.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] rd1_b1;
    logic [31:0] rd2_b1;
    logic [31:0] rd1_b0;
    logic [31:0] rd2_b0;

    int n_cmp = 0;
    int n_err = 0;

    reg_file #(
        .WIDTH  (32),
        .ADDR_W (5),
        .BYPASS (1'b1)
    ) dut_b1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (rd1_b1),
        .ReadData2 (rd2_b1)
    );

    reg_file #(
        .WIDTH  (32),
        .ADDR_W (5),
        .BYPASS (1'b0)
    ) dut_b0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (rd1_b0),
        .ReadData2 (rd2_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        RegWrite  = 1'b1;
        WriteReg  = idx;
        WriteData = val;
        tick();
        RegWrite  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        ReadReg1 = a;
        ReadReg2 = b;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        RegWrite  = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'hDEADBEEF;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;

        // reset held with a write pending on every edge
        repeat (3) tick();
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check($sformatf("rst_b1_p1[%0d]", i), rd1_b1, 32'h0);
            check($sformatf("rst_b1_p2[%0d]", i), rd2_b1, 32'h0);
            check($sformatf("rst_b0_p1[%0d]", i), rd1_b0, 32'h0);
            check($sformatf("rst_b0_p2[%0d]", i), rd2_b0, 32'h0);
        end
        RegWrite = 1'b0;
        rst_n    = 1'b1;
        rd(5'd5, 5'd5);
        check("rel_reg5_b1", rd1_b1, 32'h0);
        check("rel_reg5_b0", rd1_b0, 32'h0);
        tick();
        rd(5'd5, 5'd5);
        check("rel_reg5_edge", rd2_b1, 32'h0);

        // basic write/read
        wr(5'd7, 32'h12345678);
        wr(5'd31, 32'hFFFFFFFF);
        rd(5'd7, 5'd31);
        check("rd7_b1", rd1_b1, 32'h12345678);
        check("rd31_b1", rd2_b1, 32'hFFFFFFFF);
        check("rd7_b0", rd1_b0, 32'h12345678);
        check("rd31_b0", rd2_b0, 32'hFFFFFFFF);
        rd(5'd7, 5'd7);
        check("both7_p1", rd1_b1, 32'h12345678);
        check("both7_p2", rd2_b1, 32'h12345678);

        // register 0 ignores writes and never bypasses
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'hAAAAAAAA;
        rd(5'd0, 5'd0);
        check("zero_pre_b1_p1", rd1_b1, 32'h0);
        check("zero_pre_b1_p2", rd2_b1, 32'h0);
        check("zero_pre_b0_p1", rd1_b0, 32'h0);
        check("zero_pre_b0_p2", rd2_b0, 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("zero_post_b1_p1", rd1_b1, 32'h0);
        check("zero_post_b1_p2", rd2_b1, 32'h0);
        check("zero_post_b0_p1", rd1_b0, 32'h0);
        check("zero_post_b0_p2", rd2_b0, 32'h0);

        // same-cycle read of the register being written
        wr(5'd3, 32'h11);
        RegWrite  = 1'b1;
        WriteReg  = 5'd3;
        WriteData = 32'h22;
        rd(5'd3, 5'd3);
        check("byp_pre_b1_p1", rd1_b1, 32'h22);
        check("byp_pre_b1_p2", rd2_b1, 32'h22);
        check("byp_pre_b0_p1", rd1_b0, 32'h11);
        check("byp_pre_b0_p2", rd2_b0, 32'h11);
        tick();
        RegWrite = 1'b0;
        #1;
        check("byp_post_b1", rd1_b1, 32'h22);
        check("byp_post_b0", rd1_b0, 32'h22);

        // write disabled: no store, no bypass, X data harmless
        wr(5'd9, 32'h99);
        RegWrite  = 1'b0;
        WriteReg  = 5'd9;
        WriteData = 32'h55;
        rd(5'd9, 5'd9);
        check("wdis_pre_b1", rd1_b1, 32'h99);
        check("wdis_pre_b0", rd2_b0, 32'h99);
        repeat (4) tick();
        check("wdis_post_b1", rd1_b1, 32'h99);
        check("wdis_post_b0", rd2_b0, 32'h99);
        WriteData = 'x;
        tick();
        check("wdis_x_b1", rd1_b1, 32'h99);
        check("wdis_x_b0", rd2_b0, 32'h99);

        // fill every register, then a short async reset pulse
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        rd(5'd17, 5'd31);
        check("fill17", rd1_b1, 32'd17);
        check("fill31", rd2_b0, 32'd31);
        rst_n = 1'b0;
        #1;
        check("pulse17_b1", rd1_b1, 32'h0);
        check("pulse31_b1", rd2_b1, 32'h0);
        check("pulse17_b0", rd1_b0, 32'h0);
        check("pulse31_b0", rd2_b0, 32'h0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(i);
            #0.2;
            check($sformatf("after_pulse_b1[%0d]", i), rd1_b1, 32'h0);
            check($sformatf("after_pulse_b0[%0d]", i), rd2_b0, 32'h0);
        end
        tick();
        RegWrite  = 1'b1;
        WriteReg  = 5'd4;
        WriteData = 32'h4;
        rd(5'd4, 5'd4);
        check("w4_pre_b1", rd1_b1, 32'h4);
        check("w4_pre_b0", rd1_b0, 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("w4_post_b1", rd1_b1, 32'h4);
        check("w4_post_b0", rd2_b0, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read, one-write general-purpose register file for the single-cycle processor. It sits directly upstream of the ALU: `ReadData1` drives ALU operand `A`, and `ReadData2` drives operand `B` through the ALUSrc mux. Write-back is the ALU `Result` or load data, selected by MemtoReg. Register 0 is hardwired to zero. An optional write-through bypass lets a same-cycle read of the register being written return the new value.

## Interface
- `WIDTH`, 32, data width of each register and of all data ports
- `ADDR_W`, 5, register address width; the file holds 2^ADDR_W registers
- `BYPASS`, 1, 1 = write-through forwarding on reads; 0 = reads always return the stored value
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `RegWrite`  in  1  write enable for the current cycle
- `WriteReg`  in  ADDR_W  destination register index
- `WriteData`  in  WIDTH  value to write (ALU `Result` or memory data)
- `ReadReg1`  in  ADDR_W  source index for port 1 (rs)
- `ReadReg2`  in  ADDR_W  source index for port 2 (rt)
- `ReadData1`  out  WIDTH  port-1 data, goes to ALU `A`
- `ReadData2`  out  WIDTH  port-2 data, goes to ALU `B` / store data

## Operation
- Storage: 2^ADDR_W registers of WIDTH bits. Entry 0 is never stored; it is constant 0.
- Write:
  - On rising `clk`, if `RegWrite`=1 and `WriteReg`≠0, then reg[`WriteReg`] ← `WriteData`.
  - If `RegWrite`=0, or `WriteReg`=0, no state changes.
- Read is combinational, per port independently:
  - ReadRegN=0 → ReadDataN = 0, regardless of any other input.
  - Else, if BYPASS=1 and `RegWrite`=1 and `WriteReg`=ReadRegN → ReadDataN = `WriteData`.
  - Else → ReadDataN = reg[ReadRegN].
- Both ports may address the same register; both then return identical data, bypass included.
- No arithmetic is performed. Indices are unsigned, and every ADDR_W value is valid (no out-of-range case).
- X on `WriteData` with `RegWrite`=0 must not corrupt state.

## Timing
- Reset:
  - `rst_n` low clears all registers to 0 immediately, without waiting for a clock edge.
  - While `rst_n` is low, writes are ignored and both read ports return 0.
  - Reset asserted in the same cycle as a write: reset wins and the register stays 0.
- Release: the first write takes effect on the first rising `clk` after `rst_n` goes high.
- Write latency: 1 cycle. The written value is visible through storage from the cycle after the edge.
- Read latency: 0 cycles (combinational from ReadRegN, and from `WriteData` when bypassing).
- BYPASS=0: a read of the register being written returns the old value until the edge. This is the same-cycle read-old case the single-cycle datapath tolerates.
- Critical path: ReadRegN decode → mux → ALU `A`/`B`. The bypass compare must run in parallel with the storage mux, not in series with it.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`=32, `REG_ADDR_W`=5, `REG_ZERO`=5'd0
  - a `reg_idx_t` typedef, also reused by the instruction decoder
- Sub-module `register_32`: WIDTH-bit flop with enable, async active-low clear.
  - Instantiated 31 times (indices 1..31) through a generate loop.
  - Write enables come from a one-hot decode of `WriteReg` gated by `RegWrite`.
- Read ports are two 32:1 `mux_32`-style selects followed by a zero/bypass override. No other sub-modules.

## Test plan
- Reset: hold `rst_n`=0 and drive `RegWrite`=1, `WriteReg`=5, `WriteData`=0xDEADBEEF for 3 edges → ReadData1/2 read 0 for all 32 indices; after release, reg5 is still 0.
- Basic write/read: write reg7=0x12345678 and reg31=0xFFFFFFFF on consecutive edges; then ReadReg1=7, ReadReg2=31 → 0x12345678, 0xFFFFFFFF. Both ports on 7 → both 0x12345678.
- Zero register: write reg0=0xAAAAAAAA, then read index 0 on both ports → 0 on both, same cycle and after the edge, with BYPASS=1 and with BYPASS=0.
- Bypass: reg3 holds 0x11. Drive `RegWrite`=1, `WriteReg`=3, `WriteData`=0x22, ReadReg1=3 before the edge → BYPASS=1 reads 0x22, BYPASS=0 reads 0x11; both read 0x22 after the edge.
- Write disabled: `RegWrite`=0, `WriteReg`=9, `WriteData`=0x55 over 4 edges → reg9 unchanged at its prior value 0x99, and no bypass occurs.
- Reset mid-operation: write regs 1..31 with their own index, then pulse `rst_n` low between edges for 1 ns → all reads return 0 immediately. The next write of reg4=0x4 lands on the following edge.
